// File: rtl/dma_addr_word_counter.sv
// dma_addr_word_counter: per-channel DMA address/word-count registers with step, terminal count and optional autoinit
//   clk, reset           : clock, asynchronous active-high reset
//   wr_en/wr_ch/wr_sel   : CPU program strobe, target channel, 0=address 1=word count
//   wr_data              : program value, LSB-aligned, truncated to register width
//   step/ch_sel/dec      : one transfer done on ch_sel, address direction (1=down)
//   autoinit/tc_clr      : per-channel reload mode bits, per-channel tc_status clears
//   cur_addr/cur_word    : combinational readout of ch_sel
//   tc/tc_ch/tc_status   : registered terminal-count pulse, its channel, sticky flags
//   Define DMA_AUTOINIT_EN to reload a channel from its base registers on terminal count.
module dma_addr_word_counter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      wr_en,
  input  logic [CH_W-1:0]                           wr_ch,
  input  logic                                      wr_sel,
  input  logic [(ADDR_W>CNT_W?ADDR_W:CNT_W)-1:0]    wr_data,
  input  logic                                      step,
  input  logic [CH_W-1:0]                           ch_sel,
  input  logic                                      dec,
  input  logic [NUM_CH-1:0]                         autoinit,
  input  logic [NUM_CH-1:0]                         tc_clr,
  output logic [ADDR_W-1:0]                         cur_addr,
  output logic [CNT_W-1:0]                          cur_word,
  output logic                                      tc,
  output logic [CH_W-1:0]                           tc_ch,
  output logic [NUM_CH-1:0]                         tc_status
);
  logic [NUM_CH-1:0][ADDR_W-1:0] base_addr, cur_addr_r;
  logic [NUM_CH-1:0][CNT_W-1:0]  base_word, cur_word_r;
  logic [ADDR_W-1:0] stp_addr, nxt_addr;
  logic [CNT_W-1:0]  nxt_word;
  logic step_ok, term;
  assign cur_addr = cur_addr_r[ch_sel];
  assign cur_word = cur_word_r[ch_sel];
  // a write to the stepped channel in the same cycle discards the step
  assign step_ok  = step && (cur_word != '0) && !(wr_en && wr_ch == ch_sel);
  assign term     = step_ok && (cur_word == CNT_W'(1));
  assign stp_addr = dec ? cur_addr - ADDR_W'(1) : cur_addr + ADDR_W'(1);
`ifdef DMA_AUTOINIT_EN
  logic reload;
  assign reload   = term && autoinit[ch_sel];
  assign nxt_addr = reload ? base_addr[ch_sel] : stp_addr;
  assign nxt_word = reload ? base_word[ch_sel] : cur_word - CNT_W'(1);
`else
  logic unused_base;
  assign unused_base = &{1'b0, autoinit, base_addr, base_word};
  assign nxt_addr    = stp_addr;
  assign nxt_word    = cur_word - CNT_W'(1);
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      base_addr  <= '0;
      base_word  <= '0;
      cur_addr_r <= '0;
      cur_word_r <= '0;
      tc         <= 1'b0;
      tc_ch      <= '0;
      tc_status  <= '0;
    end else begin
      tc    <= term;
      tc_ch <= term ? ch_sel : '0;
      for (int i = 0; i < NUM_CH; i++) begin
        // set dominates a same-cycle clear
        tc_status[i] <= (term && ch_sel == CH_W'(i)) || (tc_status[i] && !tc_clr[i]);
        if (wr_en && wr_ch == CH_W'(i)) begin
          if (wr_sel) begin
            base_word[i]  <= wr_data[CNT_W-1:0];
            cur_word_r[i] <= wr_data[CNT_W-1:0];
          end else begin
            base_addr[i]  <= wr_data[ADDR_W-1:0];
            cur_addr_r[i] <= wr_data[ADDR_W-1:0];
          end
        end else if (step_ok && ch_sel == CH_W'(i)) begin
          cur_addr_r[i] <= nxt_addr;
          cur_word_r[i] <= nxt_word;
        end
      end
    end
endmodule

// File: tb/tb_dma_addr_word_counter.sv
// tb_dma_addr_word_counter: randomized and directed checks against a behavioural channel model
module tb_dma_addr_word_counter;
  logic clk = 1'b0;
  logic reset, wr_en, wr_sel, step, dec, tc;
  logic [1:0] wr_ch, ch_sel, tc_ch;
  logic [15:0] wr_data, cur_addr, cur_word;
  logic [3:0] autoinit, tc_clr, tc_status;
  int n_chk = 0, n_pass = 0;
  int m_addr[4], m_word[4], m_baddr[4], m_bword[4];
  bit [3:0] m_status;
  bit m_tc;
  int m_tc_ch;
  always #5 clk = ~clk;
  dma_addr_word_counter dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .step(step), .ch_sel(ch_sel), .dec(dec), .autoinit(autoinit),
    .tc_clr(tc_clr), .cur_addr(cur_addr), .cur_word(cur_word), .tc(tc), .tc_ch(tc_ch),
    .tc_status(tc_status)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_addr[i] = 0; m_word[i] = 0; m_baddr[i] = 0; m_bword[i] = 0;
    end
    m_status = '0; m_tc = 1'b0; m_tc_ch = 0;
  endtask
  task automatic model_step();
    int s;
    bit go, hit;
    s   = int'(ch_sel);
    go  = step && m_word[s] != 0 && !(wr_en && wr_ch == ch_sel);
    hit = go && m_word[s] == 1;
    m_status = m_status & ~tc_clr;
    if (hit) m_status[s] = 1'b1;
    if (wr_en) begin
      if (wr_sel) begin m_bword[wr_ch] = int'(wr_data); m_word[wr_ch] = int'(wr_data); end
      else begin m_baddr[wr_ch] = int'(wr_data); m_addr[wr_ch] = int'(wr_data); end
    end
    if (go) begin
      m_word[s] = m_word[s] - 1;
      m_addr[s] = (m_addr[s] + (dec ? -1 : 1)) & 32'hFFFF;
`ifdef DMA_AUTOINIT_EN
      if (hit && autoinit[s]) begin m_addr[s] = m_baddr[s]; m_word[s] = m_bword[s]; end
`endif
    end
    m_tc = hit;
    m_tc_ch = s;
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("cur_addr", 32'(cur_addr), 32'(m_addr[ch_sel]));
    chk("cur_word", 32'(cur_word), 32'(m_word[ch_sel]));
    chk("tc", 32'(tc), 32'(m_tc));
    if (m_tc) chk("tc_ch", 32'(tc_ch), 32'(m_tc_ch));
    chk("tc_status", 32'(tc_status), 32'(m_status));
  endtask
  task automatic idle();
    wr_en = 1'b0; step = 1'b0; tc_clr = '0;
  endtask
  task automatic wr(input logic [1:0] ch, input logic sel, input logic [15:0] d);
    idle(); wr_en = 1'b1; wr_ch = ch; wr_sel = sel; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic stp(input logic [1:0] ch, input logic d);
    idle(); step = 1'b1; ch_sel = ch; dec = d;
    tick();
    step = 1'b0;
  endtask
  initial begin
    reset = 1'b1; idle(); wr_ch = '0; wr_sel = 1'b0; wr_data = '0; ch_sel = '0;
    dec = 1'b0; autoinit = '0;
    model_reset();
    #1;
    chk("rst_addr", 32'(cur_addr), 32'h0);
    chk("rst_word", 32'(cur_word), 32'h0);
    chk("rst_tc", 32'(tc), 32'h0);
    chk("rst_status", 32'(tc_status), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    // ch1 increment to terminal count
    wr(2'd1, 1'b0, 16'hAB00); wr(2'd1, 1'b1, 16'd3);
    for (int k = 1; k <= 3; k++) begin
      stp(2'd1, 1'b0);
      chk("inc_addr", 32'(cur_addr), 32'h0000AB00 + 32'(k));
      chk("inc_word", 32'(cur_word), 32'(3 - k));
    end
    chk("inc_tc", 32'(tc), 32'h1);
    chk("inc_tc_ch", 32'(tc_ch), 32'h1);
    chk("inc_status", 32'(tc_status), 32'h2);
    tick();
    chk("inc_tc_single", 32'(tc), 32'h0);
    // ch2 decrement across zero, then stepping at count 0
    wr(2'd2, 1'b0, 16'h0000); wr(2'd2, 1'b1, 16'd2);
    stp(2'd2, 1'b1); chk("dec_wrap", 32'(cur_addr), 32'hFFFF);
    stp(2'd2, 1'b1); chk("dec_addr", 32'(cur_addr), 32'hFFFE); chk("dec_tc", 32'(tc), 32'h1);
    stp(2'd2, 1'b1); chk("zero_addr", 32'(cur_addr), 32'hFFFE); chk("zero_tc", 32'(tc), 32'h0);
    chk("zero_word", 32'(cur_word), 32'h0);
    // ch0 terminal count with autoinit requested
    autoinit = 4'b0001;
    wr(2'd0, 1'b0, 16'h1000); wr(2'd0, 1'b1, 16'd2);
    stp(2'd0, 1'b0); stp(2'd0, 1'b0);
    chk("ai_tc", 32'(tc), 32'h1);
`ifdef DMA_AUTOINIT_EN
    chk("ai_addr", 32'(cur_addr), 32'h1000); chk("ai_word", 32'(cur_word), 32'h2);
`else
    chk("ai_addr", 32'(cur_addr), 32'h1002); chk("ai_word", 32'(cur_word), 32'h0);
`endif
    autoinit = '0;
    // write/step collisions
    wr(2'd3, 1'b1, 16'd5);
    wr_en = 1'b1; wr_ch = 2'd3; wr_sel = 1'b1; wr_data = 16'd9; step = 1'b1; ch_sel = 2'd3;
    tick(); idle();
    chk("col_same_word", 32'(cur_word), 32'h9); chk("col_same_tc", 32'(tc), 32'h0);
    wr(2'd0, 1'b1, 16'd4);
    wr_en = 1'b1; wr_ch = 2'd3; wr_sel = 1'b1; wr_data = 16'd7; step = 1'b1; ch_sel = 2'd0; dec = 1'b0;
    tick(); idle();
    chk("col_diff_ch0", 32'(cur_word), 32'h3);
    ch_sel = 2'd3; #1;
    chk("col_diff_ch3", 32'(cur_word), 32'h7);
    // asynchronous reset mid-transfer
    wr(2'd1, 1'b1, 16'd6); stp(2'd1, 1'b0); stp(2'd1, 1'b0);
    chk("mid_word", 32'(cur_word), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("arst_addr", 32'(cur_addr), 32'h0);
    chk("arst_word", 32'(cur_word), 32'h0);
    chk("arst_tc", 32'(tc), 32'h0);
    chk("arst_tc_ch", 32'(tc_ch), 32'h0);
    chk("arst_status", 32'(tc_status), 32'h0);
    model_reset();
    @(posedge clk); #1 reset = 1'b0;
    stp(2'd1, 1'b0);
    chk("post_rst_tc", 32'(tc), 32'h0);
    // randomized traffic with short counts so terminal counts are frequent
    for (int n = 0; n < 600; n++) begin
      idle();
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_ch    = 2'($urandom);
      wr_sel   = 1'($urandom);
      wr_data  = wr_sel ? 16'($urandom_range(0, 4)) : 16'($urandom);
      step     = 1'($urandom);
      ch_sel   = 2'($urandom);
      dec      = 1'($urandom);
      autoinit = 4'($urandom);
      tc_clr   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end
    idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
